cargador_programa: RTL and testbench
====================================

# cargador_programa

Serial program loader that fills instruction memory before the pipeline runs. It accepts a byte stream through a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written through a single-cycle write port into instruction memory at consecutive word addresses. It then verifies a checksum and raises `cpu_run`, which gates the PC and pipeline buffers.

## Interface
Parameters:
- `DEPTH`, 256: instruction memory capacity in words; maximum legal word count.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  one-cycle start pulse.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  32  byte address of the word being written.
- `mem_wdata`  out  32  instruction word.
- `cpu_run`  out  1  program loaded and verified; pipeline may run.
- `err_len`  out  1  word count exceeded `DEPTH`.
- `err_sum`  out  1  checksum mismatch.

## Operation
- One clock, `clk`. Reset is asynchronous and active-high on `rst`.
- Stream format:
  - `N_hi`, `N_lo`: 16-bit word count N.
  - 4·N payload bytes, MSB first per word.
  - One checksum byte equal to the XOR of all payload bytes (0x00 when N=0).
- A byte transfers on a rising edge with `byte_valid && byte_ready`. Without a transfer, no state changes.
- States:
  - IDLE: `load_start` → LEN_HI.
  - LEN_HI: on transfer, latch N[15:8] → LEN_LO.
  - LEN_LO: on transfer, latch N[7:0].
    - N > `DEPTH` → ERROR with `err_len`=1.
    - N == 0 → CHECK.
    - Otherwise → DATA. Word index clears, checksum accumulator clears, byte counter clears.
  - DATA: on transfer, shift the byte into the assembly register (`word = {word[23:0], byte}`) and XOR it into the accumulator. On the 4th byte → WRITE.
  - WRITE: for exactly one cycle:
    - `mem_we`=1, `mem_addr`=`BASE_ADDR` + 4·index, `mem_wdata`=assembled word.
    - Then index increments.
    - If index+1 == N → CHECK, else → DATA.
  - CHECK: on transfer, compare the byte with the accumulator. Equal → DONE. Different → ERROR with `err_sum`=1.
  - DONE: `cpu_run`=1. `load_start` → LEN_HI with `cpu_run` cleared.
  - ERROR: the error flag holds. `load_start` → LEN_HI, clearing both error flags.
- `load_start` is ignored in LEN_HI, LEN_LO, DATA, WRITE and CHECK.
- `byte_ready`=1 only in LEN_HI, LEN_LO, DATA and CHECK. It is 0 in IDLE, WRITE, DONE and ERROR.
- Arithmetic and widths:
  - Index is 16 bits; the count compare is unsigned.
  - `mem_addr` is computed modulo 2^32.
  - N == `DEPTH` is legal and writes the last word at `BASE_ADDR` + 4·(`DEPTH`−1).
- Memory contents written before a reset or error are not cleared.

## Timing
- Reset value of every output is 0: `byte_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_run`, `err_len`, `err_sum`. State returns to IDLE.
- All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- Word latency: the WRITE cycle immediately follows the edge that accepted the 4th byte. Minimum 5 cycles per word.
- Throughput: with `byte_valid` held high, N words plus header and checksum take 2 + 5N + 1 accepting/writing cycles after `load_start`.
- `cpu_run` rises on the edge after the checksum byte is accepted.
- `err_len` rises on the edge after `N_lo` is accepted. No `mem_we` pulse occurs for that load.
- Simultaneous `load_start` and `byte_valid` in IDLE/DONE/ERROR: the byte is not consumed (`byte_ready`=0).
- Reset asserted mid-load: all outputs drop asynchronously and any partial word is discarded.

## Test plan
- N=1, bytes 00 01 20 08 00 05 2D, `byte_valid` held high.
  - One `mem_we` pulse with `mem_addr`=0x0 and `mem_wdata`=0x20080005.
  - `cpu_run`=1 next cycle after 0x2D.
- Same stream with checksum byte 0x2C.
  - Write occurs, then `err_sum`=1 and `cpu_run`=0.
  - A following `load_start` clears `err_sum`.
- N=0, bytes 00 00 00.
  - No `mem_we`; `cpu_run`=1.
- `DEPTH`=4, bytes 00 05.
  - `err_len`=1 one cycle after 0x05, no `mem_we`, `byte_ready`=0.
- N=2 with `byte_valid` toggling every other cycle and `BASE_ADDR`=0x100.
  - Writes at 0x100 and 0x104 with correct words.
  - No byte lost or duplicated.
  - `byte_ready`=0 during each WRITE.
- `rst` pulsed after the 2nd payload byte.
  - All outputs 0 immediately, no `mem_we`.
  - A fresh `load_start` and full stream complete normally.

Source files
------------

// File: rtl/cargador_programa_if.sv
// Byte stream and instruction-memory write bus for the program loader.
// Master drives the stream; slave is the loader.
interface cargador_programa_if;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        err_len;
  logic        err_sum;

  modport master (
    output load_start,
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_run,
    input  err_len,
    input  err_sum
  );

  modport slave (
    input  load_start,
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_run,
    output err_len,
    output err_sum
  );
endinterface

// File: rtl/cargador_programa.sv
// Serial program loader: length header, big-endian words, XOR checksum.
// Fills instruction memory, then releases the pipeline via cpu_run.
module cargador_programa #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  cargador_programa_if.slave bus
);

  localparam logic [31:0] L_DEPTH = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  logic [15:0] r_n;
  logic [15:0] r_idx;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic [31:0] r_addr;
  logic [7:0]  r_acc;
  logic        r_err_len;
  logic        r_err_sum;

  logic        w_ready;
  logic [31:0] w_n_ext;
  logic [15:0] w_idx_nxt;

  assign w_ready = (r_state == S_LEN_HI) ||
                   (r_state == S_LEN_LO) ||
                   (r_state == S_DATA)   ||
                   (r_state == S_CHECK);

  // Full word count as it will be once N_lo is latched.
  assign w_n_ext   = {16'd0, r_n[15:8], bus.byte_in};
  assign w_idx_nxt = r_idx + 16'd1;

  assign bus.byte_ready = w_ready;
  assign bus.mem_we     = (r_state == S_WRITE);
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_word;
  assign bus.cpu_run    = (r_state == S_DONE);
  assign bus.err_len    = r_err_len;
  assign bus.err_sum    = r_err_sum;

  // Loader FSM: parse header, assemble words, write, verify checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_word    <= '0;
      r_addr    <= '0;
      r_acc     <= '0;
      r_err_len <= 1'b0;
      r_err_sum <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.load_start) r_state <= S_LEN_HI;
        end
        S_LEN_HI: begin
          if (bus.byte_valid) begin
            r_n[15:8] <= bus.byte_in;
            r_state   <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (bus.byte_valid) begin
            r_n[7:0] <= bus.byte_in;
            r_idx    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            if (w_n_ext > L_DEPTH) begin
              r_err_len <= 1'b1;
              r_state   <= S_ERROR;
            end else if (w_n_ext == 32'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (bus.byte_valid) begin
            r_word <= {r_word[23:0], bus.byte_in};
            r_acc  <= r_acc ^ bus.byte_in;
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_addr  <= BASE_ADDR + {14'd0, r_idx, 2'b00};
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_idx <= w_idx_nxt;
          if (w_idx_nxt == r_n) r_state <= S_CHECK;
          else                  r_state <= S_DATA;
        end
        S_CHECK: begin
          if (bus.byte_valid) begin
            if (bus.byte_in == r_acc) begin
              r_state <= S_DONE;
            end else begin
              r_err_sum <= 1'b1;
              r_state   <= S_ERROR;
            end
          end
        end
        S_DONE: begin
          if (bus.load_start) r_state <= S_LEN_HI;
        end
        S_ERROR: begin
          if (bus.load_start) begin
            r_err_len <= 1'b0;
            r_err_sum <= 1'b0;
            r_state   <= S_LEN_HI;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cargador_programa.sv
// Randomized bench for cargador_programa with a stream-level model.
// Expected writes and final flags are derived from the byte stream.
module tb_cargador_programa;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cargador_programa_if bus ();

  cargador_programa #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          wr_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle compare: reset quiet outputs, and every write vs model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctrl", {27'd0, bus.byte_ready, bus.mem_we,
                       bus.cpu_run, bus.err_len, bus.err_sum}, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_data", bus.mem_wdata, 0);
    end else if (bus.mem_we) begin
      chk("we_ready", {31'd0, bus.byte_ready}, 0);
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexp_write: addr %h data %h expected none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        chk("wr_addr", bus.mem_addr, exp_addr_q.pop_front());
        chk("wr_data", bus.mem_wdata, exp_data_q.pop_front());
      end
      wr_cnt++;
      last_addr = bus.mem_addr;
      last_data = bus.mem_wdata;
    end
  end

  // mode: 0 valid held, 1 toggling, 2 random. abort_at>=0 stops early.
  task automatic run_load(input byte_t bs[$], input int mode,
                          input int abort_at);
    int    n;
    int    total;
    int    k;
    int    edges;
    bit    e_len;
    bit    e_sum;
    bit    v;
    bit    fire;
    byte_t x;
    n     = {bs[0], bs[1]};
    x     = 8'h00;
    e_len = (n > DEPTH);
    e_sum = 1'b0;
    if (e_len) begin
      total = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_addr_q.push_back(BASE + 32'(4 * i));
        exp_data_q.push_back({bs[2+4*i], bs[3+4*i],
                              bs[4+4*i], bs[5+4*i]});
        for (int j = 0; j < 4; j++) x ^= bs[2+4*i+j];
      end
      total = 3 + 4 * n;
      e_sum = (bs[2+4*n] != x);
    end
    if (abort_at >= 0) total = abort_at;
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.byte_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    bus.byte_in    = bs[0];
    chk("start_ready", {31'd0, bus.byte_ready}, 0);
    @(posedge clk);
    k     = 0;
    edges = 0;
    while (k < total && edges < 2000) begin
      @(negedge clk);
      bus.load_start = 1'b0;
      if (edges == 0)
        chk("start_clr", {29'd0, bus.cpu_run, bus.err_len,
                          bus.err_sum}, 0);
      case (mode)
        0:       v = 1'b1;
        1:       v = (edges % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.byte_valid = v;
      bus.byte_in    = bs[k];
      fire = v && bus.byte_ready;
      @(posedge clk);
      edges++;
      if (fire) k++;
    end
    if (k < total) begin
      checks++;
      errors++;
      $display("FAIL timeout: consumed %0d bytes required %0d", k, total);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    if (abort_at < 0) begin
      chk("cpu_run", {31'd0, bus.cpu_run}, {31'd0, !e_len && !e_sum});
      chk("err_len", {31'd0, bus.err_len}, {31'd0, e_len});
      chk("err_sum", {31'd0, bus.err_sum}, {31'd0, e_sum});
      chk("end_ready", {31'd0, bus.byte_ready}, 0);
      chk("pend_wr", exp_addr_q.size(), 0);
      if (mode == 0)
        chk("cycles", edges, e_len ? 2 : 3 + 5 * n);
    end
  endtask

  function automatic void mk_stream(output byte_t bs[$], input int n,
                                    input bit bad);
    byte_t x;
    bs.delete();
    x = 8'h00;
    bs.push_back(byte_t'(n >> 8));
    bs.push_back(byte_t'(n));
    for (int i = 0; i < 4 * n; i++) begin
      byte_t b;
      b = byte_t'($urandom);
      x ^= b;
      bs.push_back(b);
    end
    if (bad) x ^= byte_t'($urandom_range(1, 255));
    bs.push_back(x);
  endfunction

  initial begin
    byte_t bs[$];
    int    w0;
    bus.load_start = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    bs = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    w0 = wr_cnt;
    run_load(bs, 0, -1);
    chk("lit_n1_cnt", wr_cnt - w0, 1);
    chk("lit_n1_addr", last_addr, 32'h0000_0100);
    chk("lit_n1_data", last_data, 32'h2008_0005);
    chk("lit_n1_run", {31'd0, bus.cpu_run}, 1);

    bs = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    w0 = wr_cnt;
    run_load(bs, 0, -1);
    chk("lit_bad_cnt", wr_cnt - w0, 1);
    chk("lit_bad_sum", {31'd0, bus.err_sum}, 1);
    chk("lit_bad_run", {31'd0, bus.cpu_run}, 0);

    bs = '{8'h00, 8'h00, 8'h00};
    w0 = wr_cnt;
    run_load(bs, 0, -1);
    chk("lit_n0_cnt", wr_cnt - w0, 0);
    chk("lit_n0_run", {31'd0, bus.cpu_run}, 1);

    bs = '{8'h00, 8'h05};
    w0 = wr_cnt;
    run_load(bs, 0, -1);
    chk("lit_len_cnt", wr_cnt - w0, 0);
    chk("lit_len_err", {31'd0, bus.err_len}, 1);
    repeat (3) @(negedge clk);
    chk("lit_len_hold", {30'd0, bus.err_len, bus.byte_ready}, 2);

    mk_stream(bs, DEPTH, 1'b0);
    run_load(bs, 0, -1);
    chk("lit_full_addr", last_addr, 32'h0000_010C);

    mk_stream(bs, 2, 1'b0);
    w0 = wr_cnt;
    run_load(bs, 1, -1);
    chk("lit_tog_cnt", wr_cnt - w0, 2);

    mk_stream(bs, 2, 1'b0);
    w0 = wr_cnt;
    run_load(bs, 0, 4);
    #2 rst = 1'b1;
    #1;
    chk("async_ctrl", {27'd0, bus.byte_ready, bus.mem_we,
                       bus.cpu_run, bus.err_len, bus.err_sum}, 0);
    chk("async_data", bus.mem_wdata, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_no_wr", wr_cnt - w0, 0);
    mk_stream(bs, 3, 1'b0);
    run_load(bs, 0, -1);
    chk("post_rst_run", {31'd0, bus.cpu_run}, 1);

    for (int t = 0; t < 40; t++) begin
      mk_stream(bs, $urandom_range(0, DEPTH + 1),
                ($urandom_range(0, 4) == 0));
      run_load(bs, $urandom_range(0, 2), -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
